// File: rtl/pwm_tone_synth_pkg.sv
// Shared widths and helpers for the four-voice PWM tone synthesizer.
package pwm_tone_synth_pkg;

  localparam int NUM_VOICES = 4;
  localparam int NUM_REGS   = 2 * NUM_VOICES;  // half-period regs, then amplitude regs
  localparam int MIX_BITS   = 10;
  localparam int PWM_BITS   = 10;
  localparam int PER_BITS   = 16;

  // Contribution of one voice to the mix: its amplitude while the square is high.
  function automatic logic [MIX_BITS-1:0] voice_level(input logic                on,
                                                      input logic [MIX_BITS-1:0] amp);
    return on ? amp : '0;
  endfunction

endpackage

// File: rtl/pwm_tone_synth_if.sv
// Register bus from the Core: eight 16-bit PWM registers.
// Words 0..3 are voice half-periods in ticks, words 4..7 are voice amplitudes.
interface pwm_tone_synth_if;
  import pwm_tone_synth_pkg::*;

  logic [NUM_REGS-1:0][PER_BITS-1:0] pwm_reg;

  modport master (output pwm_reg);
  modport slave  (input  pwm_reg);
endinterface

// File: rtl/pwm_tone_synth_voice.sv
// One square-wave tone voice. The half-period is shadowed and only reloaded
// at a half-period edge (or while muted), so register writes never glitch
// the half-cycle that is already running.
module tone_voice
  import pwm_tone_synth_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [PER_BITS-1:0] period_in,
  output logic                phase,
  output logic                active
);

  logic [PER_BITS-1:0] cnt;
  logic [PER_BITS-1:0] per;

  // Tick-driven half-period counter; >= compare keeps a shortened period from running away.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      per   <= '0;
      phase <= 1'b0;
    end else if (tick) begin
      if (per == '0) begin
        cnt   <= '0;
        phase <= 1'b0;
        per   <= period_in;
      end else if (cnt >= per - PER_BITS'(1)) begin
        cnt   <= '0;
        phase <= ~phase;
        per   <= period_in;
      end else begin
        cnt   <= cnt + PER_BITS'(1);
      end
    end
  end

  assign active = (per != '0);

endmodule

// File: rtl/pwm_tone_synth.sv
// Four-voice square-wave tone synthesizer with a 10-bit PWM audio output.
// Prescaler -> tone voices -> registered mixer -> frame-latched PWM modulator.
module pwm_tone_synth
  import pwm_tone_synth_pkg::*;
#(
  parameter int TICK_DIV = 16,
  parameter int AMP_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  pwm_tone_synth_if.slave       bus,
  output logic                  audio_pwm,
  output logic [MIX_BITS-1:0]   sample,
  output logic                  sample_valid,
  output logic [NUM_VOICES-1:0] voice_phase
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  logic [15:0]                          tick_cnt;
  logic                                 tick;
  logic [NUM_VOICES-1:0]                ph;
  logic [NUM_VOICES-1:0]                act;
  logic [NUM_VOICES-1:0][MIX_BITS-1:0]  level;
  logic [MIX_BITS-1:0]                  mix_d;
  logic [MIX_BITS-1:0]                  mix_q;
  logic [PWM_BITS-1:0]                  pwm_cnt;
  logic                                 frame_end;

  // Prescaler: one-cycle tick every TICK_DIV clocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tick_cnt <= '0;
    else      tick_cnt <= tick ? 16'd0 : tick_cnt + 16'd1;
  end

  assign tick = (tick_cnt == TICK_LAST);

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    tone_voice u_voice (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .period_in (bus.pwm_reg[i]),
      .phase     (ph[i]),
      .active    (act[i])
    );

    // A muted voice reports low phase even if its last edge flipped it high.
    assign voice_phase[i] = ph[i] & act[i];
    // Amplitude is taken live from the register, not shadowed.
    assign level[i] = voice_level(voice_phase[i],
                                  MIX_BITS'(bus.pwm_reg[NUM_VOICES + i][AMP_BITS-1:0]));
  end

  // Sum of active voice levels; 4 x 255 fits in 10 bits without saturation.
  always_comb begin
    mix_d = '0;
    for (int i = 0; i < NUM_VOICES; i++) mix_d = mix_d + level[i];
  end

  // Mixer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mix_q <= '0;
    else      mix_q <= mix_d;
  end

  assign frame_end = &pwm_cnt;

  // Free-running PWM frame counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pwm_cnt <= '0;
    else      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
  end

  // Latch the mix only at the frame boundary so duty never changes mid-frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= frame_end;
      if (frame_end) sample <= mix_q;
    end
  end

  // Registered comparator output drives the RC stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) audio_pwm <= 1'b0;
    else      audio_pwm <= (MIX_BITS'(pwm_cnt) < sample);
  end

endmodule

// File: tb/tb_pwm_tone_synth.sv
// Bench for pwm_tone_synth: directed scenarios plus randomized register traffic,
// checked every cycle against an event-level model of voices, mixer and PWM frame.
module tb_pwm_tone_synth;
  import pwm_tone_synth_pkg::*;

  localparam int TD  = 4;
  localparam int TD2 = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rst2_n = 1'b1;
  always #5 clk = ~clk;

  pwm_tone_synth_if bus ();
  pwm_tone_synth_if bus2 ();

  logic                  audio, audio2;
  logic [MIX_BITS-1:0]   sample, sample2;
  logic                  sval, sval2;
  logic [NUM_VOICES-1:0] vph, vph2;

  pwm_tone_synth #(.TICK_DIV(TD), .AMP_BITS(8)) dut (
    .clk(clk), .rst(rst_n), .bus(bus), .audio_pwm(audio),
    .sample(sample), .sample_valid(sval), .voice_phase(vph)
  );

  pwm_tone_synth #(.TICK_DIV(TD2), .AMP_BITS(8)) dut2 (
    .clk(clk), .rst(rst2_n), .bus(bus2), .audio_pwm(audio2),
    .sample(sample2), .sample_valid(sval2), .voice_phase(vph2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each voice tracks how many ticks remain before its next edge.
  int m_tick, m_pwm, m_mixq, m_sample, m_valid, m_audio;
  int m_per[NUM_VOICES];
  int m_rem[NUM_VOICES];
  int m_ph[NUM_VOICES];

  task automatic m_reset();
    m_tick = 0; m_pwm = 0; m_mixq = 0; m_sample = 0; m_valid = 0; m_audio = 0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      m_per[v] = 0; m_rem[v] = 0; m_ph[v] = 0;
    end
  endtask

  function automatic int m_on(input int v);
    return (m_ph[v] != 0 && m_per[v] != 0) ? 1 : 0;
  endfunction

  task automatic m_step();
    int mix;
    int newp;
    bit tk;
    tk  = (m_tick == TD - 1);
    mix = 0;
    for (int v = 0; v < NUM_VOICES; v++)
      if (m_on(v) != 0) mix += int'(bus.pwm_reg[NUM_VOICES + v][7:0]);
    m_audio = (m_pwm < m_sample) ? 1 : 0;
    m_valid = (m_pwm == 1023) ? 1 : 0;
    if (m_valid != 0) m_sample = m_mixq;
    m_mixq = mix;
    if (tk) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        newp = int'(bus.pwm_reg[v]);
        if (m_per[v] == 0) begin
          m_per[v] = newp; m_rem[v] = newp; m_ph[v] = 0;
        end else begin
          m_rem[v]--;
          if (m_rem[v] == 0) begin
            m_ph[v] = 1 - m_ph[v]; m_per[v] = newp; m_rem[v] = newp;
          end
        end
      end
    end
    m_tick = (m_tick + 1) % TD;
    m_pwm  = (m_pwm + 1) % 1024;
  endtask

  // ---------------- per-cycle driver/checker ----------------
  int   cyc_n = 0;
  int   last_tog = 0;
  int   ival_q[$];
  logic prev_ph0 = 1'b0;

  task automatic cyc();
    logic [3:0] ev;
    @(posedge clk);
    #1;
    cyc_n++;
    if (rst_n) m_step();
    for (int v = 0; v < NUM_VOICES; v++) ev[v] = m_on(v) != 0;
    chk("phase",  32'(vph),    32'(ev));
    chk("sample", 32'(sample), m_sample);
    chk("valid",  32'(sval),   m_valid);
    chk("audio",  32'(audio),  m_audio);
    if (vph[0] !== prev_ph0) begin
      ival_q.push_back(cyc_n - last_tog);
      last_tog = cyc_n;
      prev_ph0 = vph[0];
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_audio"},  32'(audio),  0);
    chk({tag, "_sample"}, 32'(sample), 0);
    chk({tag, "_valid"},  32'(sval),   0);
    chk({tag, "_phase"},  32'(vph),    0);
  endtask

  // Release reset mid-cycle and time the first sample_valid.
  task automatic release_and_time(input string tag);
    int n;
    #2 rst_n = 1'b1;
    n = 0;
    while (n < 2000) begin
      cyc();
      n++;
      if (sval === 1'b1) break;
    end
    chk(tag, n, 1024);
  endtask

  task automatic wait_tog(input string tag);
    int n0;
    int n;
    n0 = ival_q.size();
    n  = 0;
    while (ival_q.size() == n0 && n < 1000) begin cyc(); n++; end
    if (ival_q.size() == n0) chk({tag, "_timeout"}, 0, 1);
  endtask

  // Find a frame with the wanted sample and count high audio clocks across it.
  task automatic meas_duty(input string tag, input int exp);
    int n;
    int h;
    n = 0;
    while (!(sval === 1'b1 && int'(sample) == exp) && n < 6000) begin cyc(); n++; end
    if (n >= 6000) chk({tag, "_found"}, 0, 1);
    else begin
      h = int'(audio);
      repeat (1023) begin cyc(); h += int'(audio); end
      chk(tag, h, exp);
    end
  endtask

  task automatic clear_regs();
    for (int i = 0; i < NUM_REGS; i++) bus.pwm_reg[i] = '0;
  endtask

  // ---------------- slow-prescaler instance: full-scale mix ----------------
  bit done2 = 1'b0;
  initial begin
    int n;
    int h;
    bit found;
    for (int i = 0; i < NUM_VOICES; i++) begin
      bus2.pwm_reg[i] = 16'd1;
      bus2.pwm_reg[NUM_VOICES + i] = 16'h00FF;
    end
    #1 rst2_n = 1'b0;
    repeat (3) @(negedge clk);
    rst2_n = 1'b1;
    found = 1'b0;
    n = 0;
    while (!found && n < 20000) begin
      @(negedge clk);
      n++;
      if (sval2 === 1'b1 && sample2 == 10'd1020) found = 1'b1;
    end
    chk("s3_found", 32'(found), 1);
    if (found) begin
      h = int'(audio2);
      repeat (1023) begin @(negedge clk); h += int'(audio2); end
      chk("s3_duty", h, 1020);
    end
    done2 = 1'b1;
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    clear_regs();
    m_reset();

    // Reset asserted before any clock edge: outputs already zero.
    #1 rst_n = 1'b0;
    #1 chk_zero("rst_noclk");
    repeat (100) cyc();
    chk_zero("rst_hold");
    release_and_time("first_valid");

    // Single voice, half-period 10 ticks = 40 clk.
    bus.pwm_reg[0] = 16'd10;
    bus.pwm_reg[4] = 16'h0080;
    repeat (300) cyc();
    ival_q.delete();
    repeat (3) wait_tog("s2_tog");
    for (int i = 0; i < 3 && i < ival_q.size(); i++) chk("s2_half", ival_q[i], 40);
    meas_duty("s2_duty128", 128);
    meas_duty("s2_duty0", 0);

    // Shorten the period mid-half-period (cnt=5).
    wait_tog("s4_sync");
    repeat (20) cyc();
    bus.pwm_reg[0] = 16'd3;
    ival_q.delete();
    repeat (3) wait_tog("s4_tog");
    if (ival_q.size() >= 3) begin
      chk("s4_cur", ival_q[0], 40);
      chk("s4_new1", ival_q[1], 12);
      chk("s4_new2", ival_q[2], 12);
    end

    // Mute, then restart.
    wait_tog("s5_sync");
    repeat (2) cyc();
    bus.pwm_reg[0] = 16'd0;
    repeat (200) cyc();
    chk("s5_muted", 32'(vph[0]), 0);
    meas_duty("s5_gone", 0);
    bus.pwm_reg[0] = 16'd5;
    ival_q.delete();
    repeat (3) wait_tog("s5_tog");
    if (ival_q.size() >= 3) begin
      chk("s5_half1", ival_q[1], 20);
      chk("s5_half2", ival_q[2], 20);
    end

    // Asynchronous reset while audio is high.
    n = 0;
    while (audio !== 1'b1 && n < 6000) begin cyc(); n++; end
    chk("s6_audio_hi", 32'(audio), 1);
    #2 rst_n = 1'b0;
    m_reset();
    #1 chk_zero("s6_async");
    repeat (10) cyc();
    release_and_time("s6_first_valid");

    // Randomized register traffic with occasional reset pulses.
    repeat (10) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if ($urandom_range(0, 3) != 0)
          bus.pwm_reg[v] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 9));
        if ($urandom_range(0, 2) != 0)
          bus.pwm_reg[NUM_VOICES + v] = 16'($urandom_range(0, 65535));
      end
      n = $urandom_range(300, 1400);
      repeat (n) begin
        cyc();
        if ($urandom_range(0, 199) == 0)
          bus.pwm_reg[$urandom_range(0, 3)] = 16'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 3) == 0) begin
        #2 rst_n = 1'b0;
        m_reset();
        #1 chk_zero("rnd_rst");
        repeat (3) cyc();
        #2 rst_n = 1'b1;
      end
    end

    n = 0;
    while (!done2 && n < 30000) begin cyc(); n++; end
    chk("s3_done", 32'(done2), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
